// File: rtl/risc16_mem_arbiter_pkg.sv
// Shared definitions for the RISC16 data-memory arbiter: the default widths,
// the lock FSM state encoding, the lock timeout, and the port indices.
package risc16_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // The lock times out once the debug port has been quiet for this many cycles.
  localparam int TIMEOUT_CYCLES = 256;
  localparam int TMO_W          = 8;

  // The cycle that carries the last debug request is the first cycle of the
  // timeout window. The unlock therefore happens on the edge that ends the
  // 255th idle cycle, which is when the idle counter holds TIMEOUT_CYCLES-2.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  // Bit positions in the two-bit request and grant vectors.
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/risc16_mem_arbiter_rr_pick.sv
// Two-way round-robin winner selection. A sole requester always wins. When
// both ports request, i_prio picks the winner (0 = CPU, 1 = debug).
module risc16_rr_pick
  import risc16_mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt
);

  // Pass a sole request straight through, and break a tie with the pointer.
  always_comb begin
    o_gnt = i_req;
    if (i_req[PORT_CPU] && i_req[PORT_DBG]) begin
      o_gnt[PORT_CPU] = ~i_prio;
      o_gnt[PORT_DBG] = i_prio;
    end
  end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Arbiter that shares one single-port data memory between the RISC16 CPU
// data port and a debug/loader port. Grants are combinational. Read data
// returns one cycle after the grant. The debug port can lock the CPU out
// until it releases the lock or stays idle long enough to time out.
module risc16_mem_arbiter
  import risc16_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  // Debug/loader port
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // Memory port
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e       r_state, w_state_nxt;
  logic             r_prio, w_prio_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             r_c_rvalid, r_d_rvalid;
  logic [DATA_W-1:0] r_c_rdata, r_d_rdata;
  logic [1:0]       w_req, w_pick;
  logic             w_c_rv, w_d_rv;

  // Mask the requests while reset is asserted. Mask the CPU while the debug port holds the lock.
  always_comb begin
    w_req           = '0;
    w_req[PORT_CPU] = c_req & ~rst & (r_state == ST_UNLOCKED);
    w_req[PORT_DBG] = d_req & ~rst;
  end

  risc16_rr_pick u_pick (
    .i_req  (w_req),
    .i_prio (r_prio),
    .o_gnt  (w_pick)
  );

  // Route the winner onto the memory port. Hold enable and write enable low when there is no grant.
  always_comb begin
    c_gnt   = w_pick[PORT_CPU];
    d_gnt   = w_pick[PORT_DBG];
    c_stall = c_req & ~c_gnt;
    m_en    = c_gnt | d_gnt;
    m_we    = d_gnt ? d_we    : (c_gnt & c_we);
    m_addr  = d_gnt ? d_addr  : c_addr;
    m_wdata = d_gnt ? d_wdata : c_wdata;
  end

  // Compute the next lock state, the next priority pointer and the next idle-timeout count.
  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_tmo_nxt   = '0;
    if (c_req && d_req && (c_gnt || d_gnt)) begin
      w_prio_nxt = c_gnt;  // the loser takes priority next time
    end
    case (r_state)
      ST_UNLOCKED: begin
        if (d_gnt && d_lock) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (d_gnt && !d_lock) begin
          w_state_nxt = ST_UNLOCKED;
        end else if (!d_req) begin
          if (r_tmo == TMO_LAST) w_state_nxt = ST_UNLOCKED;
          else                   w_tmo_nxt   = r_tmo + 1'b1;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // A read that was in flight when reset arrived must never appear as valid.
  assign w_c_rv   = r_c_rvalid & ~rst;
  assign w_d_rv   = r_d_rvalid & ~rst;
  assign c_rvalid = w_c_rv;
  assign d_rvalid = w_d_rv;
  assign c_rdata  = w_c_rv ? m_rdata : r_c_rdata;
  assign d_rdata  = w_d_rv ? m_rdata : r_d_rdata;

  // Update the state registers. Track reads in flight, and keep each port's last returned data.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments, so every register samples
    // the pre-edge values and the order of these statements does not matter.
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_prio     <= 1'b0;
      r_tmo      <= '0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_tmo      <= w_tmo_nxt;
      r_c_rvalid <= c_gnt & ~c_we;
      r_d_rvalid <= d_gnt & ~d_we;
      if (w_c_rv) r_c_rdata <= m_rdata;
      if (w_d_rv) r_d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_risc16_mem_arbiter.sv
// Self-checking bench for risc16_mem_arbiter. A behavioural model tracks the
// lock, priority, idle time, memory contents and pending reads, and it checks
// every cycle. Table vectors and directed sequences add targeted checks.
module tb_risc16_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [7:0]  c_addr, d_addr, m_addr;
  logic [15:0] c_wdata, d_wdata, m_wdata, c_rdata, d_rdata;
  logic [15:0] m_rdata = 16'h0;
  logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, m_en, m_we;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  risc16_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Data memory attached to the arbiter
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // Reference model state
  logic [15:0] md_mem [256];
  bit          md_locked, md_prio, pend_c, pend_d, chk_en;
  int          md_idle;
  logic [15:0] pend_c_data, pend_d_data, md_c_rdata, md_d_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                       input logic dr, input logic dw, input logic dl, input logic [7:0] da,
                       input logic [15:0] dd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle();
    drive(0, 0, 8'h0, 16'h0, 0, 0, 0, 8'h0, 16'h0);
  endtask

  // Called at a falling edge with the inputs already applied. Compare the
  // outputs against the model 2 ns later, then advance the model one cycle.
  task automatic sample();
    logic eg_c, eg_d, e_st, e_en, e_we, e_crv, e_drv;
    logic [7:0]  e_addr;
    logic [15:0] e_wd, e_crd, e_drd;
    logic [62:0] ev, av;
    #2;
    if (rst)            begin eg_c = 0; eg_d = 0; end
    else if (md_locked) begin eg_c = 0; eg_d = d_req; end
    else if (c_req && d_req) begin eg_c = !md_prio; eg_d = md_prio; end
    else                begin eg_c = c_req; eg_d = d_req; end
    e_st   = c_req && !eg_c;
    e_en   = eg_c || eg_d;
    e_we   = eg_c ? c_we : (eg_d ? d_we : 1'b0);
    e_addr = eg_c ? c_addr : (eg_d ? d_addr : 8'h0);
    e_wd   = e_we ? (eg_c ? c_wdata : d_wdata) : 16'h0;
    e_crv  = !rst && pend_c;
    e_drv  = !rst && pend_d;
    e_crd  = e_crv ? pend_c_data : md_c_rdata;
    e_drd  = e_drv ? pend_d_data : md_d_rdata;
    ev = {eg_c, eg_d, e_st, e_en, e_we, e_addr, e_wd, e_crv, e_drv, e_crd, e_drd};
    av = {c_gnt, d_gnt, c_stall, m_en, m_we, (m_en ? m_addr : 8'h0),
          ((m_en && m_we) ? m_wdata : 16'h0), c_rvalid, d_rvalid, c_rdata, d_rdata};
    if (chk_en) check("cycle", 64'(av), 64'(ev));
    if (rst) begin
      md_locked = 0; md_prio = 0; md_idle = 0; pend_c = 0; pend_d = 0;
      md_c_rdata = 16'h0; md_d_rdata = 16'h0;
    end else begin
      if (e_crv) md_c_rdata = pend_c_data;
      if (e_drv) md_d_rdata = pend_d_data;
      pend_c = eg_c && !c_we; pend_c_data = md_mem[c_addr];
      pend_d = eg_d && !d_we; pend_d_data = md_mem[d_addr];
      if (eg_c && c_we) md_mem[c_addr] = c_wdata;
      if (eg_d && d_we) md_mem[d_addr] = d_wdata;
      if (c_req && d_req && e_en) md_prio = eg_c;
      if (eg_d) begin
        md_locked = d_lock; md_idle = 0;
      end else if (md_locked) begin
        md_idle++;
        if (md_idle == 255) begin md_locked = 0; md_idle = 0; end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick();
    rst = 1'b0; chk_en = 1'b1;
  endtask

  typedef struct {
    logic c_req, c_we; logic [7:0] c_addr;
    logic d_req, d_we; logic [7:0] d_addr;
    logic e_cg, e_dg, e_stall, e_en, e_we; logic [7:0] e_addr;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int cnt, rvc;
    // Table vectors, applied in order from reset (prio=0, unlocked).
    vecs[0] = '{0, 0, 8'h00, 0, 0, 8'h00,  0, 0, 0, 0, 0, 8'h00};
    vecs[1] = '{1, 1, 8'h03, 0, 0, 8'h00,  1, 0, 0, 1, 1, 8'h03};
    vecs[2] = '{0, 0, 8'h00, 1, 0, 8'h04,  0, 1, 0, 1, 0, 8'h04};
    vecs[3] = '{1, 0, 8'h05, 1, 0, 8'h06,  1, 0, 0, 1, 0, 8'h05};
    vecs[4] = '{1, 0, 8'h05, 1, 1, 8'h07,  0, 1, 1, 1, 1, 8'h07};
    vecs[5] = '{1, 0, 8'h08, 1, 0, 8'h09,  1, 0, 0, 1, 0, 8'h08};
    vecs[6] = '{1, 0, 8'h0A, 0, 0, 8'h00,  1, 0, 0, 1, 0, 8'h0A};
    vecs[7] = '{1, 0, 8'h0B, 1, 0, 8'h0C,  0, 1, 1, 1, 0, 8'h0C};

    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0; md_mem[i] = 16'h0; end
    mem[8'h10] = 16'h1234; md_mem[8'h10] = 16'h1234;
    md_c_rdata = 16'h0; md_d_rdata = 16'h0; chk_en = 1'b0;
    rst = 1'b1; idle();
    @(negedge clk);

    // Sole CPU read: same-cycle grant, data on the next cycle
    do_reset();
    drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h0, 16'h0);
    sample(); check("r38_gnt", 64'(c_gnt), 64'd1); advance();
    idle();
    sample(); check("r38_rdata", 64'({c_rvalid, c_rdata}), 64'({1'b1, 16'h1234})); advance();

    // Table vectors
    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, {8'hC0, vecs[i].c_addr},
            vecs[i].d_req, vecs[i].d_we, 1'b0, vecs[i].d_addr, {8'hD0, vecs[i].d_addr});
      sample();
      check($sformatf("vec%0d", i), 64'({c_gnt, d_gnt, c_stall, m_en, m_we, m_addr}),
            64'({vecs[i].e_cg, vecs[i].e_dg, vecs[i].e_stall, vecs[i].e_en, vecs[i].e_we,
                 vecs[i].e_addr}));
      advance();
    end
    idle(); tick();

    // Continuous contention from reset alternates C,D,C,D
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h11, 16'h0, 1, 0, 0, 8'h12, 16'h0);
      sample();
      check($sformatf("r39_alt%0d", i), 64'({c_gnt, d_gnt, c_stall}),
            (i % 2 == 0) ? 64'b100 : 64'b011);
      advance();
    end
    idle(); tick();

    // Locked debug write, CPU stalled until unlock, then reads the written data
    do_reset();
    drive(0, 0, 8'h0, 16'h0, 1, 1, 1, 8'h20, 16'hBEEF); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h20, 16'h0, 0, 0, 0, 8'h0, 16'h0);
      sample(); check("r40_stall", 64'({c_gnt, c_stall}), 64'b01); advance();
    end
    drive(1, 0, 8'h20, 16'h0, 1, 1, 0, 8'h21, 16'h1111);
    sample(); check("r40_unlock", 64'({d_gnt, c_stall}), 64'b11); advance();
    drive(1, 0, 8'h20, 16'h0, 0, 0, 0, 8'h0, 16'h0);
    sample(); check("r40_cgnt", 64'(c_gnt), 64'd1); advance();
    idle();
    sample(); check("r40_rdata", 64'({c_rvalid, c_rdata}), 64'({1'b1, 16'hBEEF})); advance();

    // Lock timeout: 255 blocked cycles, then the CPU is granted
    do_reset();
    drive(0, 0, 8'h0, 16'h0, 1, 1, 1, 8'h30, 16'h5A5A); tick();
    cnt = 0;
    for (int i = 0; i < 255; i++) begin
      drive(1, 0, 8'h31, 16'h0, 0, 0, 0, 8'h0, 16'h0);
      sample(); if (c_gnt) cnt++; advance();
    end
    check("r41_blocked", 64'(cnt), 64'd0);
    sample(); check("r41_release", 64'(c_gnt), 64'd1); advance();
    idle(); tick();

    // Reset in the cycle after a granted read
    do_reset();
    drive(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h0, 16'h0); tick();
    drive(1, 0, 8'h11, 16'h0, 0, 0, 0, 8'h0, 16'h0); tick();
    rst = 1'b1;
    drive(1, 1, 8'h40, 16'hDEAD, 1, 1, 1, 8'h40, 16'hDEAD);
    sample();
    check("r42_in_rst", 64'({c_rvalid, d_rvalid, c_gnt, d_gnt, m_en, m_we}), 64'd0);
    advance();
    rst = 1'b0; idle();
    sample();
    check("r42_after", 64'({c_rvalid, d_rvalid, c_rdata, d_rdata}), 64'd0);
    check("r42_nowrite", 64'(mem[8'h40]), 64'd0);
    advance();

    // Back-to-back CPU writes at full throughput
    do_reset();
    cnt = 0; rvc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 8'(i), 16'(16'hA000 + i), 0, 0, 0, 8'h0, 16'h0);
      sample(); if (m_en) cnt++; if (c_rvalid || d_rvalid) rvc++; advance();
    end
    idle();
    sample(); if (c_rvalid || d_rvalid) rvc++; advance();
    check("r43_en_cycles", 64'(cnt), 64'd8);
    check("r43_no_rvalid", 64'(rvc), 64'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), 8'($urandom_range(0, 15)),
            16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)), 16'($urandom));
      tick();
    end
    rst = 1'b0; idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
